// File: rtl/music_pkg.sv
// Shared definitions for the melody sequencer.
//   TONE_REST / TONE_MAX : special tone codes (31 = silence, 28 = highest playable tone)
//   seq_state_e          : sequencer FSM states
//   note_t               : one stored note entry {tone, len}
package music_pkg;

  localparam logic [4:0] TONE_REST = 5'd31;
  localparam logic [4:0] TONE_MAX  = 5'd28;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StPlay  = 2'd1,
    StGap   = 2'd2,
    StPause = 2'd3
  } seq_state_e;

  typedef struct packed {
    logic [4:0] tone;
    logic [3:0] len;
  } note_t;

endpackage

// File: rtl/beat_tick.sv
// Beat divider: counts 0..P-1 and pulses tick for one cycle when it reaches P-1.
//   clk, rst_n : clock, asynchronous active-low reset
//   clear      : force the count to 0 (takes priority over hold)
//   hold       : freeze the count, no tick
//   fast       : use the halved period P = CLK_FREQ/(2*BEAT_HZ)
//   tick       : one-cycle beat strobe (combinational from the count)
module beat_tick #(
  parameter int unsigned CLK_FREQ = 100_000_000,
  parameter int unsigned BEAT_HZ  = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic hold,
  input  logic fast,
  output logic tick
);

  localparam int unsigned P_SLOW = CLK_FREQ / BEAT_HZ;
  localparam int unsigned P_FAST = CLK_FREQ / (2 * BEAT_HZ);
  localparam int unsigned CW     = (P_SLOW > 1) ? $clog2(P_SLOW) : 1;

  localparam logic [CW-1:0] LAST_SLOW = CW'(P_SLOW - 1);
  localparam logic [CW-1:0] LAST_FAST = CW'(P_FAST - 1);

  logic [CW-1:0] cnt_q, cnt_d, last;

  assign last = fast ? LAST_FAST : LAST_SLOW;

  always_comb begin
    cnt_d = cnt_q;
    tick  = 1'b0;
    if (clear) begin
      cnt_d = '0;
    end else if (!hold) begin
      if (cnt_q == last) begin
        cnt_d = '0;
        tick  = 1'b1;
      end else if (cnt_q > last) begin
        // fast was raised past the current count: wrap without a beat
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/melody_sequencer.sv
// Programmable note sequencer: plays note entries {tone, len} at a fixed beat rate.
//   clk, rst_n          : clock, asynchronous active-low reset
//   start / stop / pause: one-cycle control strobes (priority stop > start > pause)
//   loop, fast          : level controls (wrap at end of list, halved beat period)
//   last_idx            : index of the final entry, sampled at each end-of-gap decision
//   wr_en/addr/tone/len : note memory write port, accepted in any state
//   tone, sounding, busy, idx, done : registered playback status
module melody_sequencer
  import music_pkg::*;
#(
  parameter int unsigned CLK_FREQ = 100_000_000,
  parameter int unsigned BEAT_HZ  = 8,
  parameter int unsigned DEPTH    = 32,
  parameter int unsigned AW       = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          stop,
  input  logic          pause,
  input  logic          loop,
  input  logic          fast,
  input  logic [AW-1:0] last_idx,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [4:0]    wr_tone,
  input  logic [3:0]    wr_len,
  output logic [4:0]    tone,
  output logic          sounding,
  output logic          busy,
  output logic [AW-1:0] idx,
  output logic          done
);

  // Note memory (not reset)
  note_t mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= '{tone: wr_tone, len: wr_len};
    end
  end

  seq_state_e    state_q, state_d, saved_q, saved_d;
  logic [AW-1:0] idx_q, idx_d, load_addr;
  logic [4:0]    tone_q, tone_d;
  logic [3:0]    len_q, len_d, note_cnt_q, note_cnt_d;
  logic          sounding_q, sounding_d, busy_q, busy_d, done_q, done_d;
  logic          load, start_go, tick, tick_hold;
  note_t         load_entry;

  assign load_entry = mem_q[load_addr];
  assign tick_hold  = (state_q == StIdle) || (state_q == StPause);

  beat_tick #(
    .CLK_FREQ (CLK_FREQ),
    .BEAT_HZ  (BEAT_HZ)
  ) u_beat_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (start_go),
    .hold  (tick_hold),
    .fast  (fast),
    .tick  (tick)
  );

  always_comb begin
    state_d    = state_q;
    saved_d    = saved_q;
    idx_d      = idx_q;
    tone_d     = tone_q;
    len_d      = len_q;
    note_cnt_d = note_cnt_q;
    done_d     = 1'b0;
    load       = 1'b0;
    load_addr  = idx_q;
    start_go   = 1'b0;

    if (stop) begin
      state_d = StIdle;
    end else if (start) begin
      start_go  = 1'b1;
      state_d   = StPlay;
      idx_d     = '0;
      load      = 1'b1;
      load_addr = '0;
    end else begin
      if (tick) begin
        case (state_q)
          StPlay: begin
            if (note_cnt_q == len_q - 4'd1) begin
              state_d    = StGap;
              note_cnt_d = '0;
            end else begin
              note_cnt_d = note_cnt_q + 4'd1;
            end
          end
          StGap: begin
            if (idx_q < last_idx) begin
              idx_d     = idx_q + 1'b1;
              load      = 1'b1;
              load_addr = idx_q + 1'b1;
              state_d   = StPlay;
            end else if (loop) begin
              idx_d     = '0;
              load      = 1'b1;
              load_addr = '0;
              state_d   = StPlay;
            end else begin
              state_d = StIdle;
              done_d  = 1'b1;
            end
          end
          default: ;
        endcase
      end
      // A beat landing on the pause edge is applied first, so pausing never loses it.
      if (pause) begin
        if (state_q == StPause) begin
          state_d = saved_q;
        end else if (state_q != StIdle && state_d != StIdle) begin
          saved_d = state_d;
          state_d = StPause;
        end
      end
    end

    if (load) begin
      tone_d     = load_entry.tone;
      len_d      = (load_entry.len == 4'd0) ? 4'd1 : load_entry.len;
      note_cnt_d = '0;
    end

    sounding_d = (state_d == StPlay) && (tone_d != TONE_REST);
    busy_d     = (state_d != StIdle);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      saved_q    <= StPlay;
      idx_q      <= '0;
      tone_q     <= '0;
      len_q      <= 4'd1;
      note_cnt_q <= '0;
      sounding_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      saved_q    <= saved_d;
      idx_q      <= idx_d;
      tone_q     <= tone_d;
      len_q      <= len_d;
      note_cnt_q <= note_cnt_d;
      sounding_q <= sounding_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign tone     = tone_q;
  assign sounding = sounding_q;
  assign busy     = busy_q;
  assign idx      = idx_q;
  assign done     = done_q;

endmodule

// File: tb/tb_melody_sequencer.sv
// Directed bench for melody_sequencer with CLK_FREQ=100, BEAT_HZ=10 (tick every 10 clk,
// every 5 clk with fast=1). Each vector applies one-cycle strobes/writes, then checks the
// expected outputs on each of the next n cycles.
module tb_melody_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start, stop, pause, loop, fast, wr_en;
  logic [4:0] last_idx, wr_addr, wr_tone;
  logic [3:0] wr_len;
  logic [4:0] tone;
  logic       sounding, busy, done;
  logic [4:0] idx;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    string      name;
    bit         st, sp, pa, we;
    logic [4:0] wa, wt;
    logic [3:0] wl;
    int         n;
    logic [4:0] tone;
    bit         snd, busy;
    logic [4:0] idx;
    bit         done;
  } vec_t;

  vec_t vecs[$];

  melody_sequencer #(
    .CLK_FREQ (100),
    .BEAT_HZ  (10),
    .DEPTH    (32),
    .AW       (5)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .stop     (stop),
    .pause    (pause),
    .loop     (loop),
    .fast     (fast),
    .last_idx (last_idx),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_tone  (wr_tone),
    .wr_len   (wr_len),
    .tone     (tone),
    .sounding (sounding),
    .busy     (busy),
    .idx      (idx),
    .done     (done)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(string nm, int cyc, logic [12:0] exp);
    logic [12:0] act;
    act = {tone, sounding, busy, idx, done};
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got tone=%0d snd=%0b busy=%0b idx=%0d done=%0b, want tone=%0d snd=%0b busy=%0b idx=%0d done=%0b",
               nm, cyc, act[12:8], act[7], act[6], act[5:1], act[0],
               exp[12:8], exp[7], exp[6], exp[5:1], exp[0]);
    end
  endtask

  task automatic write_note(logic [4:0] a, logic [4:0] t, logic [3:0] l);
    wr_en   = 1'b1;
    wr_addr = a;
    wr_tone = t;
    wr_len  = l;
    step();
    wr_en   = 1'b0;
  endtask

  task automatic add(string nm, bit st, bit sp, bit pa, int n,
                     logic [4:0] t, bit s, bit b, logic [4:0] i, bit d);
    vec_t v;
    v.name = nm; v.st = st; v.sp = sp; v.pa = pa;
    v.we = 1'b0; v.wa = '0; v.wt = '0; v.wl = '0;
    v.n = n; v.tone = t; v.snd = s; v.busy = b; v.idx = i; v.done = d;
    vecs.push_back(v);
  endtask

  // Attach a memory write to the most recently added vector
  task automatic add_wr(logic [4:0] a, logic [4:0] t, logic [3:0] l);
    vecs[vecs.size()-1].we = 1'b1;
    vecs[vecs.size()-1].wa = a;
    vecs[vecs.size()-1].wt = t;
    vecs[vecs.size()-1].wl = l;
  endtask

  task automatic run_vecs();
    foreach (vecs[k]) begin
      start   = vecs[k].st;
      stop    = vecs[k].sp;
      pause   = vecs[k].pa;
      wr_en   = vecs[k].we;
      wr_addr = vecs[k].wa;
      wr_tone = vecs[k].wt;
      wr_len  = vecs[k].wl;
      for (int c = 0; c < vecs[k].n; c++) begin
        step();
        start = 1'b0;
        stop  = 1'b0;
        pause = 1'b0;
        wr_en = 1'b0;
        check(vecs[k].name, c, {vecs[k].tone, vecs[k].snd, vecs[k].busy, vecs[k].idx,
                                vecs[k].done});
      end
    end
    vecs.delete();
  endtask

  initial begin
    rst_n = 1'b1;
    start = 1'b0; stop = 1'b0; pause = 1'b0; loop = 1'b0; fast = 1'b0;
    wr_en = 1'b0; wr_addr = '0; wr_tone = '0; wr_len = '0; last_idx = '0;
    #2 rst_n = 1'b0;
    #1 check("reset_state", 0, 13'd0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    step();

    // Basic play: {0,2},{4,1},{31,3}
    write_note(5'd0, 5'd0, 4'd2);
    write_note(5'd1, 5'd4, 4'd1);
    write_note(5'd2, 5'd31, 4'd3);
    last_idx = 5'd2;
    add("basic_note0", 1, 0, 0, 20, 5'd0, 1, 1, 5'd0, 0);
    add("basic_gap0",  0, 0, 0, 10, 5'd0, 0, 1, 5'd0, 0);
    add("basic_note1", 0, 0, 0, 10, 5'd4, 1, 1, 5'd1, 0);
    add("basic_gap1",  0, 0, 0, 10, 5'd4, 0, 1, 5'd1, 0);
    add("basic_rest",  0, 0, 0, 40, 5'd31, 0, 1, 5'd2, 0);
    add("basic_done",  0, 0, 0, 1,  5'd31, 0, 0, 5'd2, 1);
    add("basic_idle",  0, 0, 0, 5,  5'd31, 0, 0, 5'd2, 0);
    // stop / pause in IDLE do nothing
    add("idle_stop",   0, 1, 0, 5,  5'd31, 0, 0, 5'd2, 0);
    add("idle_pause",  0, 0, 1, 5,  5'd31, 0, 0, 5'd2, 0);
    add("replay",      1, 0, 0, 7,  5'd0, 1, 1, 5'd0, 0);
    run_vecs();

    // Asynchronous reset mid-playback
    #3 rst_n = 1'b0;
    #1 check("async_reset", 0, 13'd0);
    step();
    step();
    rst_n = 1'b1;
    add("post_reset_idle", 0, 0, 0, 25, 5'd0, 0, 0, 5'd0, 0);
    run_vecs();

    // Loop with len=0 treated as 1
    write_note(5'd0, 5'd7, 4'd0);
    last_idx = 5'd0;
    loop     = 1'b1;
    add("loop_play", 1, 0, 0, 10, 5'd7, 1, 1, 5'd0, 0);
    add("loop_gap",  0, 0, 0, 10, 5'd7, 0, 1, 5'd0, 0);
    for (int r = 0; r < 2; r++) begin
      add("loop_play", 0, 0, 0, 10, 5'd7, 1, 1, 5'd0, 0);
      add("loop_gap",  0, 0, 0, 10, 5'd7, 0, 1, 5'd0, 0);
    end
    add("loop_stop", 0, 1, 0, 15, 5'd7, 0, 0, 5'd0, 0);
    run_vecs();

    // Pause / resume keeps total note time
    write_note(5'd0, 5'd5, 4'd2);
    loop = 1'b0;
    add("pause_pre",    1, 0, 0, 5,  5'd5, 1, 1, 5'd0, 0);
    add("pause_hold",   0, 0, 1, 30, 5'd5, 0, 1, 5'd0, 0);
    add("pause_resume", 0, 0, 1, 15, 5'd5, 1, 1, 5'd0, 0);
    add("pause_gap",    0, 0, 0, 10, 5'd5, 0, 1, 5'd0, 0);
    add("pause_done",   0, 0, 0, 1,  5'd5, 0, 0, 5'd0, 1);
    add("pause_idle",   0, 0, 0, 3,  5'd5, 0, 0, 5'd0, 0);
    run_vecs();

    // Simultaneous strobes and restart while busy
    start = 1'b1; pause = 1'b1;
    add("start_pause", 1, 0, 1, 8, 5'd5, 1, 1, 5'd0, 0);
    add("start_stop",  1, 1, 0, 5, 5'd5, 0, 0, 5'd0, 0);
    add("restart_a",   1, 0, 0, 12, 5'd5, 1, 1, 5'd0, 0);
    add("restart_b",   1, 0, 0, 20, 5'd5, 1, 1, 5'd0, 0);
    add("restart_gap", 0, 0, 0, 10, 5'd5, 0, 1, 5'd0, 0);
    add("restart_done", 0, 0, 0, 1, 5'd5, 0, 0, 5'd0, 1);
    run_vecs();

    // Fast mode and live write of the playing entry
    write_note(5'd0, 5'd2, 4'd1);
    write_note(5'd1, 5'd3, 4'd2);
    last_idx = 5'd1;
    loop     = 1'b1;
    fast     = 1'b1;
    add("fast_n0",      1, 0, 0, 5, 5'd2, 1, 1, 5'd0, 0);
    add("fast_g0",      0, 0, 0, 5, 5'd2, 0, 1, 5'd0, 0);
    add("fast_n1",      0, 0, 0, 4, 5'd3, 1, 1, 5'd1, 0);
    add("live_wr_n1",   0, 0, 0, 6, 5'd3, 1, 1, 5'd1, 0);
    add_wr(5'd1, 5'd9, 4'd1);
    add("fast_g1",      0, 0, 0, 5, 5'd3, 0, 1, 5'd1, 0);
    add("fast_n0b",     0, 0, 0, 5, 5'd2, 1, 1, 5'd0, 0);
    add("fast_g0b",     0, 0, 0, 5, 5'd2, 0, 1, 5'd0, 0);
    add("live_new_n1",  0, 0, 0, 5, 5'd9, 1, 1, 5'd1, 0);
    add("live_new_g1",  0, 0, 0, 5, 5'd9, 0, 1, 5'd1, 0);
    add("fast_wrap",    0, 0, 0, 2, 5'd2, 1, 1, 5'd0, 0);
    add("fast_stop",    0, 1, 0, 3, 5'd2, 0, 0, 5'd0, 0);
    run_vecs();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
